// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a shared-memory multicycle MIPS datapath.
// Sequences FETCH/DECODE plus per-class execute states, drives the datapath
// mux selects and write enables, and stalls memory states on memready.
module multicycle_controller #(
    parameter int USE_MEMREADY = 1,
    parameter int OP_WIDTH     = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [OP_WIDTH-1:0] funct,
    input  logic                zero,
    input  logic                memready,
    output logic                memread,
    output logic                memwrite,
    output logic                iord,
    output logic                irwrite,
    output logic                pcen,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [2:0]          alucontrol,
    output logic                instr_done,
    output logic                illegal
);

    // Opcode encodings
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

    // Funct encodings for R-type ALU operations
    localparam logic [OP_WIDTH-1:0] FN_ADD = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] FN_SUB = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] FN_AND = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] FN_OR  = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] FN_SLT = OP_WIDTH'(6'b101010);

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Mux select codes
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;

    // Unknown functs fall back to ADD without flagging anything.
    function automatic logic [2:0] alu_from_funct(input logic [OP_WIDTH-1:0] f);
        logic [2:0] code;
        case (f)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_SLT:  code = ALU_SLT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // With the handshake disabled every memory access completes in one cycle.
    assign mem_rdy = (USE_MEMREADY != 0) ? memready : 1'b1;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d    = state_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PC_ALU;
        alucontrol = ALU_AND;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                // Read instruction at PC and compute PC+4 in the same cycle;
                // IR and PC update only when the read completes.
                memread    = 1'b1;
                iord       = 1'b0;
                alusrca    = 1'b0;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                pcsrc      = PC_ALU;
                irwrite    = mem_rdy;
                pcen       = mem_rdy;
                state_d    = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alusrca    = 1'b0;
                alusrcb    = SRCB_IMMSH2;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b0;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                // Write request is held for the whole stall.
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_rdy;
                state_d    = mem_rdy ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_REG;
                alucontrol = alu_from_funct(funct);
                state_d    = ALUWB;
            end
            ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                memtoreg   = 1'b0;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                // Compare A and B; take the target held in ALUOut when equal.
                alusrca    = 1'b1;
                alusrcb    = SRCB_REG;
                alucontrol = ALU_SUB;
                pcsrc      = PC_ALUOUT;
                pcen       = zero;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b0;
                memtoreg   = 1'b0;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc      = PC_JUMP;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // No write or handshake pulses may escape while reset is held.
        if (reset) begin
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcen       = 1'b0;
            regwrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-memory, multicycle MIPS datapath: one ALU, one unified instruction/data memory, and an instruction register.
- Runs each instruction over 3–5 states, driving the datapath muxes and write enables.
- Decodes opcode/funct, and stalls on a memory ready handshake.
- It is the sequential counterpart of the single-cycle controller and sits beside the multicycle datapath under the mips top.

Parameters:
- USE_MEMREADY, 1, when 1 the memory states wait for memready; when 0 memready is treated as constant 1.
- OP_WIDTH, 6, opcode and funct field width (fixed encodings below assume 6).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- memready  input  1  memory has completed the current read or write this cycle
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  output  1  instruction register load enable
- pcen  output  1  PC load enable
- regwrite  output  1  register file write enable
- regdst  output  1  write register select: 1 = rd, 0 = rt
- memtoreg  output  1  write-back data select: 1 = data register, 0 = ALUOut
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal  output  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- Opcode map: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Funct map: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Any other funct gives 010 and raises no error.
- The state register resets asynchronously to FETCH.
  - While reset is high, memread, memwrite, irwrite, pcen, regwrite, instr_done and illegal are forced to 0.
  - All outputs are combinational from state, memready, zero and op/funct (Moore outputs, plus memready/zero gating).
- Every output not listed for a state is 0.
- FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = 010, pcsrc = 00.
  - irwrite and pcen are 1 only in the cycle where memready = 1; the FSM then moves to DECODE, otherwise it stays in FETCH.
- DECODE: alusrca = 0, alusrcb = 11, alucontrol = 010 (branch target computed into ALUOut). Next state:
  - LW/SW → MEMADR
  - R-type → EXECUTE
  - BEQ → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - anything else → FETCH, with illegal = 1 for that cycle
- MEMADR: alusrca = 1, alusrcb = 10, alucontrol = 010. Next state: LW → MEMRD, SW → MEMWR.
- MEMRD: memread = 1, iord = 1. Holds until memready = 1, then → MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1, instr_done = 1. Next state → FETCH.
- MEMWR: memwrite = 1, iord = 1, held for the whole wait.
  - instr_done = 1 only in the memready = 1 cycle, then → FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00, alucontrol from the funct map. Next state → ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0, instr_done = 1. Next state → FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, alucontrol = 110, pcsrc = 01, pcen = zero, instr_done = 1. Next state → FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, alucontrol = 010. Next state → ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0, instr_done = 1. Next state → FETCH.
- JUMP: pcsrc = 10, pcen = 1, instr_done = 1. Next state → FETCH.
- Latency with memready tied to 1, in cycles including FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- memread and memwrite are never both 1. irwrite is only ever 1 in FETCH.
- op and funct are sampled only outside FETCH (the IR is stable there). Changes to op/funct during FETCH have no effect.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately, asynchronously.
  - No enable pulses occur during reset.
  - After reset deasserts, the first rising edge evaluates FETCH.
- Unused state encodings → FETCH.

Test Plan:
- Reset, memready = 1, LW (op 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite = 1 and memtoreg = 1 only in cycle 5; instr_done pulses once in cycle 5.
- SW with memready low for 3 cycles in MEMWR → memwrite held 1 for 4 cycles, iord = 1, instr_done only in the 4th cycle, then FETCH.
- R-type SUB (funct 100010), then BEQ with zero = 1, then BEQ with zero = 0:
  - SUB: alucontrol = 110 in EXECUTE and regdst = 1 in ALUWB.
  - BEQ, zero = 1: pcen = 1 and pcsrc = 01 in BRANCH.
  - BEQ, zero = 0: pcen = 0.
- FETCH with memready = 0 for 2 cycles, then 1 → irwrite and pcen are 0, 0, then 1; DECODE follows.
- Opcode 111111 → illegal pulses 1 in DECODE and the next state is FETCH; J (000010) → pcsrc = 10 and pcen = 1, 3 cycles total.
- Assert reset while in MEMRD during a stall → outputs are 0 immediately; after release, the FSM starts in FETCH with memread = 1.
